// File: rtl/trig_pkg.sv
// Shared constants for the multi-channel coincidence trigger.
//
// Contents:
//   StArmed / StHoldoff  - trigger FSM state codes
//   WIN_* / MULT_*       - bit fields of the 16-bit mconfig word
//   Def*                 - default parameter values
package trig_pkg;

    // FSM state codes
    localparam logic [0:0] StArmed   = 1'b0;
    localparam logic [0:0] StHoldoff = 1'b1;

    // mconfig fields: [7:0] window, [11:8] multiplicity, [15:12] reserved
    localparam int unsigned WIN_LSB  = 0;
    localparam int unsigned WIN_W    = 8;
    localparam int unsigned MULT_LSB = 8;
    localparam int unsigned MULT_W   = 4;

    // Defaults
    localparam int unsigned DefNch     = 4;
    localparam int unsigned DefCntW    = 8;
    localparam int unsigned DefWindow  = 15;
    localparam int unsigned DefMult    = 2;
    localparam int unsigned DefHoldoff = 32;

endpackage

// File: rtl/coinc_channel_timer.sv
// One coincidence-window timer for a single trigger channel.
//
// A masked rising edge on sig_i loads the window length; the counter then
// counts down to 0 and saturates there. clear_i has priority over everything.
// The channel window is open while the counter is non-zero.
//
// Ports:
//   clk_i    - system clock
//   rst_ni   - asynchronous active-low reset
//   sig_i    - discriminator input, synchronous to clk_i
//   mask_i   - 1 = edges on this channel may open a window
//   clear_i  - force the counter to 0 (holdoff, readout, after a fire)
//   win_i    - window length to load on an edge (already forced >= 1)
//   open_o   - window currently open
module coinc_channel_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sig_i,
    input  logic             mask_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] win_i,
    output logic             open_o
);

    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sig_rise;

    // prev_q tracks the input in every state, so a level held through
    // holdoff or readout never produces a late edge.
    assign sig_rise = sig_i & ~prev_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (sig_rise && mask_i) begin
            cnt_d = win_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= sig_i;
            cnt_q  <= cnt_d;
        end
    end

    assign open_o = (cnt_q != '0);

endmodule

// File: rtl/multi_coinc_trigger.sv
// N-channel coincidence trigger.
//
// Each enabled channel opens a programmable window on a rising edge. When at
// least `mult` windows are open at once a one-cycle TRIGGER_OUT fires, the open
// vector is latched into HIT_PATTERN, TRIG_COUNT increments and the block sits
// in holdoff for HOLDOFF cycles with all windows cleared.
//
// Optional feature (macro COINC_VETO_EN): adds VETO input and VETO_COUNT
// output. VETO suppresses the fire; each suppressed fire is counted once and
// the windows are then cleared.
//
// Ports:
//   CLK          - system clock
//   RESET        - asynchronous active-low reset
//   SIGNAL       - discriminator inputs, synchronous to CLK
//   ch_mask      - per-channel enable
//   read_mode    - readout busy; clears windows and inhibits triggering
//   mconfig      - [7:0] window, [11:8] multiplicity, [15:12] ignored
//   VETO         - (COINC_VETO_EN) suppress firing
//   VETO_COUNT   - (COINC_VETO_EN) number of vetoed fires, wraps
//   TRIGGER_OUT  - one-cycle trigger pulse
//   HIT_PATTERN  - open-window vector at the last trigger
//   TRIG_COUNT   - number of triggers issued, wraps
module multi_coinc_trigger
    import trig_pkg::*;
#(
    parameter int unsigned NCH        = DefNch,
    parameter int unsigned CNT_W      = DefCntW,
    parameter int unsigned DEF_WINDOW = DefWindow,
    parameter int unsigned DEF_MULT   = DefMult,
    parameter int unsigned HOLDOFF    = DefHoldoff
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic [NCH-1:0] SIGNAL,
    input  logic [NCH-1:0] ch_mask,
    input  logic           read_mode,
    input  logic [15:0]    mconfig,
`ifdef COINC_VETO_EN
    input  logic           VETO,
    output logic [15:0]    VETO_COUNT,
`endif
    output logic           TRIGGER_OUT,
    output logic [NCH-1:0] HIT_PATTERN,
    output logic [15:0]    TRIG_COUNT
);

    localparam int unsigned HoldW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    logic [0:0]        state_q, state_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [MULT_W-1:0] mult_q, mult_d;
    logic              trig_q;
    logic [NCH-1:0]    hit_q, hit_d;
    logic [15:0]       tcount_q;

    logic [NCH-1:0]    open_w;
    logic [3:0]        pop;
    logic [WIN_W-1:0]  win_eff;
    logic [CNT_W-1:0]  win_load;
    logic [MULT_W-1:0] mult_eff;
    logic              armed;
    logic              coinc;
    logic              fire;
    logic              clear_all;
    logic              cfg_load;

    logic unused_cfg;
    assign unused_cfg = ^mconfig[15:12];

    // Zero-valued window/multiplicity fields behave as 1.
    assign win_eff  = (win_q == '0) ? WIN_W'(1) : win_q;
    assign win_load = CNT_W'(win_eff);
    assign mult_eff = (mult_q == '0) ? MULT_W'(1) : mult_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        coinc_channel_timer #(
            .CNT_W (CNT_W)
        ) u_timer (
            .clk_i   (CLK),
            .rst_ni  (RESET),
            .sig_i   (SIGNAL[g]),
            .mask_i  (ch_mask[g]),
            .clear_i (clear_all),
            .win_i   (win_load),
            .open_o  (open_w[g])
        );
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NCH; i++) begin
            pop = pop + 4'(open_w[i]);
        end
    end

    assign armed = (state_q == StArmed);
    // mult above NCH can never be reached by pop, so no special case is needed.
    assign coinc = armed && !read_mode && (pop >= mult_eff);

`ifdef COINC_VETO_EN
    logic        veto_hit;
    logic [15:0] vcount_q;
    assign veto_hit = coinc & VETO;
    assign fire     = coinc & ~VETO;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            vcount_q <= '0;
        end else if (veto_hit) begin
            vcount_q <= vcount_q + 16'd1;
        end
    end
    assign VETO_COUNT = vcount_q;
`else
    assign fire = coinc;
`endif

    // A vetoed coincidence also clears the windows so it is counted only once.
    assign clear_all = !armed || read_mode || coinc;

    // Config only changes while nothing is open, so a window never mixes settings.
    assign cfg_load = armed && (open_w == '0);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        win_d   = win_q;
        mult_d  = mult_q;
        hit_d   = hit_q;
        if (cfg_load) begin
            win_d  = mconfig[WIN_LSB +: WIN_W];
            mult_d = mconfig[MULT_LSB +: MULT_W];
        end
        if (armed) begin
            if (fire) begin
                state_d = StHoldoff;
                hold_d  = HoldW'(HOLDOFF - 1);
                hit_d   = open_w;
            end
        end else if (hold_q == '0) begin
            state_d = StArmed;
        end else begin
            hold_d = hold_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= StArmed;
            hold_q   <= '0;
            win_q    <= WIN_W'(DEF_WINDOW);
            mult_q   <= MULT_W'(DEF_MULT);
            trig_q   <= 1'b0;
            hit_q    <= '0;
            tcount_q <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            win_q    <= win_d;
            mult_q   <= mult_d;
            trig_q   <= fire;
            hit_q    <= hit_d;
            tcount_q <= tcount_q + 16'(fire);
        end
    end

    assign TRIGGER_OUT = trig_q;
    assign HIT_PATTERN = hit_q;
    assign TRIG_COUNT  = tcount_q;

endmodule

// File: doc/multi_coinc_trigger.md
Name: multi_coinc_trigger

Overview:
N-channel coincidence trigger, parametrised successor to the two-channel edge trigger handler. Each enabled channel opens a programmable coincidence window on a rising edge. A trigger pulse fires when at least M windows are open at the same time. After each trigger the block applies a fixed holdoff and latches which channels took part, for readout by the ESP32 interface logic.

Parameters:
NCH, 4, number of input channels (2..8)
CNT_W, 8, width of the per-channel window counter
DEF_WINDOW, 15, window length (cycles) loaded at reset
DEF_MULT, 2, minimum multiplicity loaded at reset
HOLDOFF, 32, dead-time cycles after each trigger (>=1)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-low reset
SIGNAL  in  NCH  discriminator inputs, already synchronous to CLK
ch_mask  in  NCH  1 = channel participates
read_mode  in  1  readout busy; inhibits triggering
mconfig  in  16  [7:0] window length, [11:8] multiplicity, [15:12] reserved (ignored)
TRIGGER_OUT  out  1  one-cycle trigger pulse
HIT_PATTERN  out  NCH  open-window vector captured at last trigger
TRIG_COUNT  out  16  number of triggers issued; wraps 0xFFFF->0

Behaviour:
- Reset (RESET=0, async): all counters 0, TRIGGER_OUT=0, HIT_PATTERN=0, TRIG_COUNT=0, state=ARMED, window=DEF_WINDOW, mult=DEF_MULT, edge-history regs=0.
- Edge detect: edge[i] = SIGNAL[i] & ~prev[i]. prev is registered every cycle in all states. A held-high input yields exactly one edge.
- Config latch: window/mult regs load from mconfig on any ARMED cycle where all channel counters are 0; otherwise they hold. window=0 is treated as 1. mult=0 is treated as 1. mult>NCH means triggering can never occur.
- Channel counter (ARMED, read_mode=0): edge & ch_mask loads window. Otherwise the counter decrements and saturates at 0. A re-edge while open reloads (extends) the window. open[i] = (cnt[i]!=0).
- States:
  - ARMED: if read_mode=0 and popcount(open) >= mult, then on the next edge TRIGGER_OUT=1 for one cycle, HIT_PATTERN<=open, TRIG_COUNT++, all counters cleared, goto HOLDOFF.
  - HOLDOFF: a holdoff counter runs HOLDOFF cycles. Edges are ignored and counters stay 0. On expiry, goto ARMED.
- Latency: edges on M channels sampled at edge k load counters at k. TRIGGER_OUT is high for the cycle following edge k+1.
- read_mode=1 in ARMED: counters are forced to 0, edges are ignored, and no trigger fires. read_mode does not shorten HOLDOFF.
- Simultaneous edges on >=mult channels in one cycle fire. Channel with ch_mask=0 never opens. Clearing ch_mask while a window is open lets it decay normally.
- Window edges: a channel opened at k is open for exactly `window` cycles (k..k+window-1). Coincidence requires overlap within that span.
- Reset mid-HOLDOFF or mid-window: immediate return to reset values.

Optional Feature:
COINC_VETO_EN
- With the macro: adds input VETO (1 bit) and output VETO_COUNT (16 bits, wraps, reset 0).
  - VETO=1 in ARMED suppresses the fire exactly as read_mode does, but counters are not cleared.
  - Each cycle in which the fire condition is met but suppressed by VETO increments VETO_COUNT. That cycle is counted once, and the counters are then cleared to avoid recounting.
- Without the macro: both ports are absent and behaviour is as above.

Decomposition:
- Package trig_pkg holds:
  - state enum (ARMED, HOLDOFF)
  - mconfig field offsets/widths (WIN_LSB=0, WIN_W=8, MULT_LSB=8, MULT_W=4)
  - default constants
- One sub-module, coinc_channel_timer, instantiated NCH times. It contains edge detect, mask gating, load/saturating decrement, clear/inhibit inputs, and the open output.
- Popcount, FSM, holdoff counter and output registers stay in the top level.

Test Plan:
1. Defaults: SIGNAL[0] rises at cycle 10, SIGNAL[1] at cycle 20 -> TRIGGER_OUT 1-cycle pulse at 21, HIT_PATTERN=0011, TRIG_COUNT=1.
2. Window boundary (window=15): SIGNAL[0] at 10, SIGNAL[2] at 25 -> no trigger. Repeat with SIGNAL[2] at 24 -> trigger, HIT_PATTERN=0101.
3. mult=3 via mconfig=0x0305: 3 simultaneous edges -> trigger. Re-run with 2 edges -> none. Also check that mconfig is not latched while a window is open.
4. Holdoff: trigger, then edges on all channels 5 cycles later -> no trigger. Repeat edges 34 cycles after the trigger -> trigger, TRIG_COUNT=2.
5. Inhibit/mask: read_mode=1 during coincident edges -> no trigger, counters 0. ch_mask=1110 with edges on ch0 and ch1 -> no trigger.
6. Async reset asserted mid-HOLDOFF, between clock edges -> all outputs 0 immediately. After release, a coincidence triggers with default config. Under COINC_VETO_EN, VETO=1 during a coincidence -> VETO_COUNT=1 and no trigger.
